// File: rtl/hwpe_stream_merge_align.sv
// Per-lane alignment buffer ahead of the stream merge stage: each lane is queued in a
// small FIFO and one wide beat is presented only when every lane holds a word.
module hwpe_stream_merge_align #(
    parameter int unsigned NB_IN_STREAMS = 2,
    parameter int unsigned DATA_WIDTH_IN = 32,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clear_i,
    input  logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     push_data_i,
    input  logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   push_strb_i,
    input  logic [NB_IN_STREAMS-1:0]                   push_valid_i,
    output logic [NB_IN_STREAMS-1:0]                   push_ready_o,
    output logic [NB_IN_STREAMS*DATA_WIDTH_IN-1:0]     pop_data_o,
    output logic [NB_IN_STREAMS*DATA_WIDTH_IN/8-1:0]   pop_strb_o,
    output logic                                       pop_valid_o,
    input  logic                                       pop_ready_i,
    output logic [NB_IN_STREAMS-1:0]                   lane_empty_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH_IN / 8;
    localparam int unsigned PTR_WIDTH  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] FULL_COUNT = CNT_WIDTH'(FIFO_DEPTH);

    logic [NB_IN_STREAMS-1:0] lane_valid;
    logic                     pop_fire;

    // Valid is a pure function of the occupancy counters, so it can never depend on ready.
    assign pop_valid_o = &lane_valid;
    assign pop_fire    = pop_valid_o & pop_ready_i;

    for (genvar i = 0; i < NB_IN_STREAMS; i++) begin : gen_lane
        logic [DATA_WIDTH_IN-1:0] data_mem [FIFO_DEPTH];
        logic [STRB_WIDTH-1:0]    strb_mem [FIFO_DEPTH];
        logic [PTR_WIDTH-1:0]     wptr;
        logic [PTR_WIDTH-1:0]     rptr;
        logic [CNT_WIDTH-1:0]     count;
        logic                     push_fire;

        // A full lane stays not-ready even while being popped: no same-cycle pass-through.
        assign push_ready_o[i] = (count != FULL_COUNT);
        assign lane_valid[i]   = (count != '0);
        assign lane_empty_o[i] = (count == '0);
        assign push_fire       = push_valid_i[i] & push_ready_o[i];

        always_ff @(posedge clk_i) begin
            if (push_fire) begin
                data_mem[wptr] <= push_data_i[i*DATA_WIDTH_IN +: DATA_WIDTH_IN];
                strb_mem[wptr] <= push_strb_i[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i || clear_i) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push_fire) begin
                    wptr <= wptr + 1'b1;
                end
                if (pop_fire) begin
                    rptr <= rptr + 1'b1;
                end
                case ({push_fire, pop_fire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        assign pop_data_o[i*DATA_WIDTH_IN +: DATA_WIDTH_IN] = data_mem[rptr];
        assign pop_strb_o[i*STRB_WIDTH +: STRB_WIDTH]       = strb_mem[rptr];
    end

endmodule

// File: tb/tb_hwpe_stream_merge_align.sv
// Bench for hwpe_stream_merge_align: directed scenarios on a 2-lane instance and a
// random valid/ready run on a 4-lane instance, both checked against per-lane queue models.
module tb_hwpe_stream_merge_align;

    typedef logic [35:0] ent_t;
    typedef ent_t ent_q_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear;

    logic [63:0]  d2_data;  logic [7:0]  d2_strb;  logic [1:0] d2_valid, d2_ready, d2_empty;
    logic [63:0]  p2_data;  logic [7:0]  p2_strb;  logic p2_valid, p2_ready;
    logic [127:0] d4_data;  logic [15:0] d4_strb;  logic [3:0] d4_valid, d4_ready, d4_empty;
    logic [127:0] p4_data;  logic [15:0] p4_strb;  logic p4_valid, p4_ready;

    int total = 0;
    int bad   = 0;

    hwpe_stream_merge_align #(.NB_IN_STREAMS(2), .DATA_WIDTH_IN(32), .FIFO_DEPTH(4)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .push_data_i(d2_data), .push_strb_i(d2_strb), .push_valid_i(d2_valid), .push_ready_o(d2_ready),
        .pop_data_o(p2_data), .pop_strb_o(p2_strb), .pop_valid_o(p2_valid), .pop_ready_i(p2_ready),
        .lane_empty_o(d2_empty)
    );

    hwpe_stream_merge_align #(.NB_IN_STREAMS(4), .DATA_WIDTH_IN(32), .FIFO_DEPTH(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear),
        .push_data_i(d4_data), .push_strb_i(d4_strb), .push_valid_i(d4_valid), .push_ready_o(d4_ready),
        .pop_data_o(p4_data), .pop_strb_o(p4_strb), .pop_valid_o(p4_valid), .pop_ready_i(p4_ready),
        .lane_empty_o(d4_empty)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input int l, input logic [31:0] w);
        d2_data[l*32 +: 32] = w;
        d2_strb[l*4 +: 4]   = w[3:0] | 4'h1;
    endtask

    task automatic do_reset(input bit use_clear);
        if (use_clear) clear = 1'b1; else rst = 1'b1;
        step();
        rst   = 1'b0;
        clear = 1'b0;
    endtask

    // Queue model: a lane accepts while it holds fewer than 4 words, a beat exists when every queue is non-empty.
    ent_q_t q2 [2];
    bit     live2 = 0;
    always @(negedge clk) begin
        logic       ev;
        logic [1:0] er, ee;
        logic [63:0] ed;
        logic [7:0]  es;
        ev = 1'b1; ed = '0; es = '0;
        for (int l = 0; l < 2; l++) begin
            er[l] = (q2[l].size() < 4);
            ee[l] = (q2[l].size() == 0);
            if (ee[l]) ev = 1'b0;
            else begin
                ed[l*32 +: 32] = q2[l][0][31:0];
                es[l*4 +: 4]   = q2[l][0][35:32];
            end
        end
        if (live2) begin
            chk("m2_valid", p2_valid, ev);
            chk("m2_ready", d2_ready, er);
            chk("m2_empty", d2_empty, ee);
            if (ev) begin
                chk("m2_data", p2_data, ed);
                chk("m2_strb", p2_strb, es);
            end
        end
        if (rst || clear) begin
            for (int l = 0; l < 2; l++) q2[l].delete();
            live2 = 1;
        end else if (live2) begin
            for (int l = 0; l < 2; l++) begin
                if (ev && p2_ready) void'(q2[l].pop_front());
                if (d2_valid[l] && er[l]) q2[l].push_back({d2_strb[l*4 +: 4], d2_data[l*32 +: 32]});
            end
        end
    end

    ent_q_t q4 [4];
    bit     live4 = 0;
    int     pops4 = 0;
    always @(negedge clk) begin
        logic        ev;
        logic [3:0]  er, ee;
        logic [127:0] ed;
        logic [15:0]  es;
        ev = 1'b1; ed = '0; es = '0;
        for (int l = 0; l < 4; l++) begin
            er[l] = (q4[l].size() < 4);
            ee[l] = (q4[l].size() == 0);
            if (ee[l]) ev = 1'b0;
            else begin
                ed[l*32 +: 32] = q4[l][0][31:0];
                es[l*4 +: 4]   = q4[l][0][35:32];
            end
        end
        if (live4) begin
            chk("m4_valid", p4_valid, ev);
            chk("m4_ready", d4_ready, er);
            chk("m4_empty", d4_empty, ee);
            if (ev) begin
                chk("m4_data", p4_data, ed);
                chk("m4_strb", p4_strb, es);
            end
        end
        if (rst || clear) begin
            for (int l = 0; l < 4; l++) q4[l].delete();
            live4 = 1;
        end else if (live4) begin
            if (ev && p4_ready) pops4++;
            for (int l = 0; l < 4; l++) begin
                if (ev && p4_ready) void'(q4[l].pop_front());
                if (d4_valid[l] && er[l]) q4[l].push_back({d4_strb[l*4 +: 4], d4_data[l*32 +: 32]});
            end
        end
    end

    initial begin
        logic [1:0] acc;
        logic [3:0] acc4;
        int popped, cyc, n1, min_seq, pops_at_drain;
        int seq4 [4];

        rst = 1'b1; clear = 1'b0;
        d2_data = '0; d2_strb = '0; d2_valid = '0; p2_ready = 1'b0;
        d4_data = '0; d4_strb = '0; d4_valid = '0; p4_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_valid2", p2_valid, 1'b0);
        chk("rst_ready2", d2_ready, 2'b11);
        chk("rst_empty2", d2_empty, 2'b11);
        chk("rst_valid4", p4_valid, 1'b0);
        chk("rst_empty4", d4_empty, 4'hF);

        // Aligned streaming: one beat per cycle, first beat one cycle after first push.
        p2_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set2(0, 32'hA0 + k); set2(1, 32'hB0 + k); d2_valid = 2'b11;
            if (k == 0) chk("t1_pre_valid", p2_valid, 1'b0);
            step();
            chk("t1_valid", p2_valid, 1'b1);
            chk("t1_data", p2_data, {32'hB0 + k, 32'hA0 + k});
        end
        d2_valid = '0;
        step();
        chk("t1_drained", p2_valid, 1'b0);

        // Skew: lane1 arrives three cycles after lane0.
        do_reset(1'b0);
        p2_ready = 1'b0;
        set2(0, 32'h11); d2_valid = 2'b01;
        step();
        d2_valid = '0;
        for (int c = 1; c <= 3; c++) begin
            chk("t2_empty", d2_empty, 2'b10);
            chk("t2_valid_lo", p2_valid, 1'b0);
            if (c == 3) begin set2(1, 32'h22); d2_valid = 2'b10; end
            step();
        end
        d2_valid = '0;
        chk("t2_valid_hi", p2_valid, 1'b1);
        chk("t2_data", p2_data, 64'h00000022_00000011);
        step();
        chk("t2_hold", p2_data, 64'h00000022_00000011);
        p2_ready = 1'b1;
        step();
        p2_ready = 1'b0;
        chk("t2_popped", p2_valid, 1'b0);

        // Back-pressure: lane0 fills, fifth word is held until a pop frees a slot.
        do_reset(1'b0);
        for (int j = 0; j < 4; j++) begin
            set2(0, 32'h100 + j); d2_valid = 2'b01;
            chk("t3_ready_pre", d2_ready[0], 1'b1);
            step();
        end
        set2(0, 32'h104); d2_valid = 2'b01;
        chk("t3_full", d2_ready[0], 1'b0);
        step();
        chk("t3_held", d2_ready[0], 1'b0);
        p2_ready = 1'b1;
        n1 = 0; set2(1, 32'h200); d2_valid = 2'b11;
        popped = 0; cyc = 0;
        while (popped < 5 && cyc < 30) begin
            acc = d2_valid & d2_ready;
            if (p2_valid) begin
                chk("t3_order", p2_data[31:0], 32'h100 + popped);
                popped++;
            end
            step(); cyc++;
            if (acc[0]) d2_valid[0] = 1'b0;
            if (acc[1]) begin n1++; set2(1, 32'h200 + n1); end
        end
        chk("t3_count", popped, 5);
        d2_valid = '0; p2_ready = 1'b0;

        // Steady push+pop at occupancy 2 across three full pointer wraps.
        do_reset(1'b0);
        for (int j = 0; j < 2; j++) begin
            set2(0, 32'h400 + j); set2(1, 32'h500 + j); d2_valid = 2'b11;
            step();
        end
        p2_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            set2(0, 32'h400 + n + 2); set2(1, 32'h500 + n + 2); d2_valid = 2'b11;
            chk("t4_valid", p2_valid, 1'b1);
            chk("t4_data", p2_data, {32'h500 + n, 32'h400 + n});
            chk("t4_empty", d2_empty, 2'b00);
            chk("t4_ready", d2_ready, 2'b11);
            step();
        end
        d2_valid = '0; p2_ready = 1'b0;

        // Reset / clear mid-operation with a push in the same cycle: nothing stale may emerge.
        for (int r = 0; r < 2; r++) begin
            do_reset(1'b0);
            for (int j = 0; j < 3; j++) begin
                set2(0, 32'h600 + j); d2_valid = 2'b01;
                step();
            end
            set2(0, 32'h6FF); d2_valid = 2'b01;
            do_reset(r == 1);
            d2_valid = '0;
            chk("t5_valid", p2_valid, 1'b0);
            chk("t5_empty", d2_empty, 2'b11);
            chk("t5_ready", d2_ready, 2'b11);
            step();
            set2(0, 32'h700); set2(1, 32'h800); d2_valid = 2'b11;
            step();
            d2_valid = '0;
            chk("t5_fresh", p2_data, {32'h800, 32'h700});
            chk("t5_fresh_v", p2_valid, 1'b1);
            p2_ready = 1'b1;
            step();
            p2_ready = 1'b0;
            chk("t5_after", p2_valid, 1'b0);
        end

        // Random valid/ready on the 4-lane instance; lane rates differ to exercise fill and stall.
        do_reset(1'b0);
        pops_at_drain = pops4;
        acc4 = '0;
        for (int l = 0; l < 4; l++) seq4[l] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int l = 0; l < 4; l++) begin
                if (acc4[l]) seq4[l]++;
                if (!d4_valid[l] || acc4[l]) begin
                    d4_valid[l]         = ($urandom_range(0, 7) < (7 - l));
                    d4_data[l*32 +: 32] = {8'(l), 24'(seq4[l])};
                    d4_strb[l*4 +: 4]   = 4'($urandom_range(0, 15));
                end
            end
            p4_ready = ($urandom_range(0, 3) != 0);
            acc4 = d4_valid & d4_ready;
            step();
        end
        for (int l = 0; l < 4; l++) if (acc4[l]) seq4[l]++;
        d4_valid = '0;
        p4_ready = 1'b1;
        cyc = 0;
        while (p4_valid && cyc < 20) begin step(); cyc++; end
        chk("rnd_drain", p4_valid, 1'b0);
        min_seq = seq4[0];
        for (int l = 1; l < 4; l++) if (seq4[l] < min_seq) min_seq = seq4[l];
        chk("rnd_beats", pops4 - pops_at_drain, min_seq);
        p4_ready = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
